// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI bus arbiter: FSM encoding, requester count,
// counter width, parameter defaults and timer load-value helpers.
package spi_arb_pkg;

   localparam int NREQ               = 2;
   localparam int CNT_W              = 16;
   localparam int GAP_CYCLES_DEF     = 8;
   localparam int TIMEOUT_CYCLES_DEF = 65535;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWNED = 2'd1,
      ST_BUSY  = 2'd2,
      ST_GAP   = 2'd3
   } state_e;

   // cs_n is high for the GAP state plus the one IDLE arbitration cycle, so the
   // GAP state itself runs gap-1 cycles (never fewer than one). The timer
   // expires on its zero count, hence the extra -1.
   function automatic logic [CNT_W-1:0] gap_load(input int gap);
      if (gap <= 2) return '0;
      return CNT_W'(gap - 2);
   endfunction

   // Watchdog counts the spi_start cycle as BUSY cycle 0; expiry is detected in
   // BUSY cycle cycles-1 so the timeout pulse appears cycles clocks after spi_start.
   function automatic logic [CNT_W-1:0] timeout_load(input int cycles);
      if (cycles <= 1) return '0;
      return CNT_W'(cycles - 1);
   endfunction

endpackage

// File: rtl/spi_arb_timer.sv
// Shared down-counter for the GAP interval and the BUSY watchdog.
// load_i has priority over dec_i; zero_o flags the terminal count.
module spi_arb_timer
   import spi_arb_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: reload, or step down until the terminal count.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/spi_bus_arbiter.sv
// Two-requester arbiter in front of a shared SPI byte engine and SD card chip
// select. Round-robin ownership, optional bus lock across bytes, enforced
// cs_n-high gap between owners and a per-byte watchdog.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | no owner, cs_n high, arbitrating pending requests
//   ST_OWNED | owner holds cs_n low, waiting for its start pulse
//   ST_BUSY  | byte in flight on the engine, watchdog running
//   ST_GAP   | ownership released, cs_n held high before re-arbitration
module spi_bus_arbiter
   import spi_arb_pkg::*;
#(
   parameter int GAP_CYCLES     = GAP_CYCLES_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
)
(
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic [NREQ-1:0] req_i,
   input  logic [NREQ-1:0] lock_i,
   input  logic [NREQ-1:0] start_i,
   input  logic [7:0]      tx_data0_i,
   input  logic [7:0]      tx_data1_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [NREQ-1:0] done_o,
   output logic [7:0]      rx_data_o,
   output logic            timeout_err_o,
   output logic            spi_start_o,
   output logic [7:0]      spi_data_in_o,
   input  logic            spi_done_i,
   input  logic [7:0]      spi_data_out_i,
   output logic            cs_n_o
);

   localparam logic [CNT_W-1:0] GAP_LD = gap_load(GAP_CYCLES);
   localparam logic [CNT_W-1:0] TO_LD  = timeout_load(TIMEOUT_CYCLES);

   state_e          state_q, state_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [NREQ-1:0] done_q, done_d;
   logic            owner_q, owner_d;
   logic            prio_q, prio_d;
   logic [7:0]      rx_data_q, rx_data_d;
   logic            timeout_q, timeout_d;
   logic            spi_start_q, spi_start_d;
   logic [7:0]      spi_data_in_q, spi_data_in_d;

   logic            tmr_load;
   logic [CNT_W-1:0] tmr_val;
   logic            tmr_dec;
   logic            tmr_zero;
   logic            win;

   spi_arb_timer u_timer (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .dec_i      (tmr_dec),
      .zero_o     (tmr_zero)
   );

   // Round-robin pick: a lone requester wins, a tie goes to prio_q.
   always_comb begin
      if (req_i == 2'b11) win = prio_q;
      else                win = req_i[1];
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d       = state_q;
      gnt_d         = gnt_q;
      owner_d       = owner_q;
      prio_d        = prio_q;
      done_d        = '0;
      rx_data_d     = rx_data_q;
      timeout_d     = 1'b0;
      spi_start_d   = 1'b0;
      spi_data_in_d = spi_data_in_q;
      tmr_load      = 1'b0;
      tmr_val       = '0;
      tmr_dec       = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (req_i != '0) begin
               owner_d = win;
               prio_d  = ~win;
               gnt_d   = 2'b01 << win;
               state_d = ST_OWNED;
            end
         end
         ST_OWNED: begin
            if (start_i[owner_q]) begin
               spi_start_d   = 1'b1;
               spi_data_in_d = owner_q ? tx_data1_i : tx_data0_i;
               tmr_load      = 1'b1;
               tmr_val       = TO_LD;
               state_d       = ST_BUSY;
            end else if (!lock_i[owner_q]) begin
               gnt_d    = '0;
               tmr_load = 1'b1;
               tmr_val  = GAP_LD;
               state_d  = ST_GAP;
            end
         end
         ST_BUSY: begin
            // Completion wins over a watchdog expiry in the same cycle.
            if (spi_done_i) begin
               rx_data_d = spi_data_out_i;
               done_d    = 2'b01 << owner_q;
               if (lock_i[owner_q]) begin
                  state_d = ST_OWNED;
               end else begin
                  gnt_d    = '0;
                  tmr_load = 1'b1;
                  tmr_val  = GAP_LD;
                  state_d  = ST_GAP;
               end
            end else if (tmr_zero) begin
               rx_data_d = 8'hFF;
               done_d    = 2'b01 << owner_q;
               timeout_d = 1'b1;
               gnt_d     = '0;
               tmr_load  = 1'b1;
               tmr_val   = GAP_LD;
               state_d   = ST_GAP;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         ST_GAP: begin
            if (tmr_zero) state_d = ST_IDLE;
            else          tmr_dec = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= ST_IDLE;
         gnt_q         <= '0;
         done_q        <= '0;
         owner_q       <= 1'b0;
         prio_q        <= 1'b0;
         rx_data_q     <= '0;
         timeout_q     <= 1'b0;
         spi_start_q   <= 1'b0;
         spi_data_in_q <= '0;
      end else begin
         state_q       <= state_d;
         gnt_q         <= gnt_d;
         done_q        <= done_d;
         owner_q       <= owner_d;
         prio_q        <= prio_d;
         rx_data_q     <= rx_data_d;
         timeout_q     <= timeout_d;
         spi_start_q   <= spi_start_d;
         spi_data_in_q <= spi_data_in_d;
      end
   end

   assign gnt_o         = gnt_q;
   assign done_o        = done_q;
   assign rx_data_o     = rx_data_q;
   assign timeout_err_o = timeout_q;
   assign spi_start_o   = spi_start_q;
   assign spi_data_in_o = spi_data_in_q;
   assign cs_n_o        = ~|gnt_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter: directed stimulus with scoreboard queues for
// grants, engine starts and byte completions.
module tb_spi_bus_arbiter;

   typedef struct {
      logic [1:0] d;
      logic [7:0] rx;
      logic       to;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] req_i = '0;
   logic [1:0] lock_i = '0;
   logic [1:0] start_i = '0;
   logic [7:0] tx_data0_i = '0;
   logic [7:0] tx_data1_i = '0;
   logic       spi_done_i = 1'b0;
   logic [7:0] spi_data_out_i = '0;
   logic [1:0] gnt_o;
   logic [1:0] done_o;
   logic [7:0] rx_data_o;
   logic       timeout_err_o;
   logic       spi_start_o;
   logic [7:0] spi_data_in_o;
   logic       cs_n_o;

   int n_chk = 0;
   int n_fail = 0;

   exp_t       q_done[$];
   logic [7:0] q_tx[$];
   logic [1:0] q_gnt[$];
   logic [1:0] prev_gnt = '0;

   spi_bus_arbiter #(.GAP_CYCLES(8), .TIMEOUT_CYCLES(32)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .req_i          (req_i),
      .lock_i         (lock_i),
      .start_i        (start_i),
      .tx_data0_i     (tx_data0_i),
      .tx_data1_i     (tx_data1_i),
      .gnt_o          (gnt_o),
      .done_o         (done_o),
      .rx_data_o      (rx_data_o),
      .timeout_err_o  (timeout_err_o),
      .spi_start_o    (spi_start_o),
      .spi_data_in_o  (spi_data_in_o),
      .spi_done_i     (spi_done_i),
      .spi_data_out_i (spi_data_out_i),
      .cs_n_o         (cs_n_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Scoreboard monitor, sampling on the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_gnt = '0;
      end else begin
         if (spi_start_o) begin
            if (q_tx.size() == 0) chk("spi_start_unexp", spi_start_o, 1'b0);
            else chk("sb_spi_data_in", spi_data_in_o, q_tx.pop_front());
         end
         if (done_o != 2'b00) begin
            if (q_done.size() == 0) begin
               chk("done_unexp", done_o, 2'b00);
            end else begin
               exp_t e;
               e = q_done.pop_front();
               chk("sb_done", done_o, e.d);
               chk("sb_rx_data", rx_data_o, e.rx);
               chk("sb_timeout_err", timeout_err_o, e.to);
            end
         end else if (timeout_err_o) begin
            chk("timeout_without_done", timeout_err_o, 1'b0);
         end
         if (prev_gnt == 2'b00 && gnt_o != 2'b00) begin
            if (q_gnt.size() == 0) chk("gnt_unexp", gnt_o, 2'b00);
            else chk("sb_gnt_order", gnt_o, q_gnt.pop_front());
         end
         prev_gnt = gnt_o;
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req_i = '0; lock_i = '0; start_i = '0; spi_done_i = 1'b0;
      q_done.delete(); q_tx.delete(); q_gnt.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_gnt(input logic [1:0] g, input int budget);
      for (int i = 0; i < budget && gnt_o !== g; i++) @(negedge clk);
      chk("wait_gnt", gnt_o, g);
   endtask

   // Count cs_n-high cycles starting at the current falling edge.
   task automatic gap_len(input int exp);
      int n;
      n = 0;
      while (cs_n_o && n < 50) begin
         n++;
         @(negedge clk);
      end
      chk("gap_len", n, exp);
   endtask

   // Called at the first falling edge where the owner's grant is visible.
   task automatic send_byte(input logic o, input logic [7:0] data, input logic lk,
                            input int dly, input logic [7:0] rx, input logic poke);
      exp_t e;
      logic [1:0] oh;
      oh = o ? 2'b10 : 2'b01;
      e.d = oh; e.rx = rx; e.to = 1'b0;
      q_tx.push_back(data);
      q_done.push_back(e);
      lock_i[o] = lk;
      if (o) tx_data1_i = data; else tx_data0_i = data;
      start_i = oh;
      @(negedge clk);
      start_i = '0;
      chk("spi_start_lat", spi_start_o, 1'b1);
      chk("spi_data_in", spi_data_in_o, data);
      if (poke) begin
         start_i = 2'b11;
         @(negedge clk);
         start_i = '0;
      end
      repeat (dly) @(negedge clk);
      spi_data_out_i = rx;
      spi_done_i = 1'b1;
      @(negedge clk);
      spi_done_i = 1'b0;
      chk("done_lat", done_o, oh);
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      exp_t e;
      int n;
      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_gnt", gnt_o, 2'b00);
      chk("rst_done", done_o, 2'b00);
      chk("rst_spi_start", spi_start_o, 1'b0);
      chk("rst_spi_data_in", spi_data_in_o, 8'h00);
      chk("rst_rx_data", rx_data_o, 8'h00);
      chk("rst_timeout", timeout_err_o, 1'b0);
      chk("rst_cs_n", cs_n_o, 1'b1);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single byte from requester 0
      q_gnt.push_back(2'b01);
      req_i = 2'b01;
      wait_gnt(2'b01, 10);
      chk("owned_cs_n", cs_n_o, 1'b0);
      req_i = 2'b00;
      send_byte(1'b0, 8'h40, 1'b0, 16, 8'h01, 1'b0);
      chk("rx_data_single", rx_data_o, 8'h01);
      @(negedge clk);
      chk("cs_n_after_done", cs_n_o, 1'b1);
      repeat (12) @(negedge clk);

      // Simultaneous requests: 0,1,0 with 8-cycle cs_n-high gaps
      do_reset();
      q_gnt.push_back(2'b01); q_gnt.push_back(2'b10); q_gnt.push_back(2'b01);
      req_i = 2'b11;
      wait_gnt(2'b01, 10);
      send_byte(1'b0, 8'h11, 1'b0, 4, 8'h21, 1'b0);
      gap_len(8);
      chk("rr_second", gnt_o, 2'b10);
      send_byte(1'b1, 8'h12, 1'b0, 5, 8'h22, 1'b0);
      gap_len(8);
      chk("rr_third", gnt_o, 2'b01);
      req_i = 2'b00;
      send_byte(1'b0, 8'h13, 1'b0, 2, 8'h23, 1'b0);
      repeat (12) @(negedge clk);

      // Locked multi-byte ownership with competing request
      do_reset();
      q_gnt.push_back(2'b01); q_gnt.push_back(2'b10);
      lock_i = 2'b01;
      req_i = 2'b11;
      wait_gnt(2'b01, 10);
      send_byte(1'b0, 8'h51, 1'b1, 3, 8'hA1, 1'b1);
      chk("lock_gnt_1", gnt_o, 2'b01);
      start_i = 2'b10;
      @(negedge clk);
      start_i = '0;
      chk("nonowner_start", spi_start_o, 1'b0);
      chk("lock_gnt_idle", gnt_o, 2'b01);
      send_byte(1'b0, 8'hFF, 1'b1, 6, 8'hA2, 1'b1);
      chk("lock_gnt_2", gnt_o, 2'b01);
      send_byte(1'b0, 8'hFF, 1'b0, 1, 8'hA3, 1'b0);
      gap_len(8);
      chk("lock_switch", gnt_o, 2'b10);
      req_i = 2'b00;
      repeat (14) @(negedge clk);
      chk("lock_release_idle", gnt_o, 2'b00);

      // Watchdog expiry, lock held (must still release)
      q_gnt.push_back(2'b01);
      lock_i = 2'b01;
      req_i = 2'b01;
      wait_gnt(2'b01, 10);
      req_i = 2'b00;
      e.d = 2'b01; e.rx = 8'hFF; e.to = 1'b1;
      q_tx.push_back(8'h77); q_done.push_back(e);
      tx_data0_i = 8'h77;
      start_i = 2'b01;
      @(negedge clk);
      start_i = '0;
      n = 0;
      while (done_o == 2'b00 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("timeout_cycle", n, 32);
      chk("timeout_err", timeout_err_o, 1'b1);
      chk("timeout_rx", rx_data_o, 8'hFF);
      @(negedge clk);
      chk("timeout_cs_n", cs_n_o, 1'b1);
      chk("timeout_pulse_len", timeout_err_o, 1'b0);
      lock_i = 2'b00;
      repeat (12) @(negedge clk);

      // spi_done in the expiry cycle counts as normal completion
      q_gnt.push_back(2'b01);
      req_i = 2'b01;
      wait_gnt(2'b01, 10);
      req_i = 2'b00;
      e.d = 2'b01; e.rx = 8'h3C; e.to = 1'b0;
      q_tx.push_back(8'h78); q_done.push_back(e);
      tx_data0_i = 8'h78;
      start_i = 2'b01;
      @(negedge clk);
      start_i = '0;
      repeat (31) @(negedge clk);
      spi_data_out_i = 8'h3C;
      spi_done_i = 1'b1;
      @(negedge clk);
      spi_done_i = 1'b0;
      chk("edge_done", done_o, 2'b01);
      chk("edge_no_timeout", timeout_err_o, 1'b0);
      chk("edge_rx", rx_data_o, 8'h3C);
      repeat (12) @(negedge clk);

      // Reset while BUSY, then a late spi_done
      q_gnt.push_back(2'b01);
      req_i = 2'b01;
      wait_gnt(2'b01, 10);
      req_i = 2'b00;
      q_tx.push_back(8'h99);
      tx_data0_i = 8'h99;
      start_i = 2'b01;
      @(negedge clk);
      start_i = '0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      q_done.delete(); q_tx.delete(); q_gnt.delete();
      #1;
      chk("rb_gnt", gnt_o, 2'b00);
      chk("rb_cs_n", cs_n_o, 1'b1);
      chk("rb_spi_data_in", spi_data_in_o, 8'h00);
      chk("rb_rx_data", rx_data_o, 8'h00);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      spi_data_out_i = 8'hAA;
      spi_done_i = 1'b1;
      @(negedge clk);
      spi_done_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("rb_no_done", done_o, 2'b00);
         @(negedge clk);
      end
      chk("rb_rx_after", rx_data_o, 8'h00);
      chk("rb_idle_gnt", gnt_o, 2'b00);
      chk("rb_idle_cs_n", cs_n_o, 1'b1);
      chk("rb_timeout", timeout_err_o, 1'b0);
      chk("rb_spi_start", spi_start_o, 1'b0);

      // Everything promised must have been delivered
      chk("sb_done_left", q_done.size(), 0);
      chk("sb_tx_left", q_tx.size(), 0);
      chk("sb_gnt_left", q_gnt.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
